// File: rtl/multicycle_alu.sv
// Registered ALU with single-cycle logic/arithmetic ops and iterative unsigned
// multiply (shift-add) and divide (restoring), one bit per clock.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] acc_hi, acc_lo, operand;
  logic is_div;
  logic is_multi;

  logic [WIDTH:0] add_sum, sub_diff;
  logic add_ov, sub_ov;
  logic [WIDTH-1:0] alu_result;
  logic alu_carry, alu_ov, alu_valid;

  logic [WIDTH:0] mul_sum, div_shift, div_diff;
  logic div_ok;

  assign is_multi = (op == 4'd8) || (op == 4'd9);
  assign ready    = (state != RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // DONE accepts a new start exactly like IDLE, giving back-to-back throughput
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = is_multi ? RUN : DONE;
        else       state_next = IDLE;
      end
      RUN:     if (count == '0) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    add_sum  = {1'b0, in1} + {1'b0, in2};
    sub_diff = {1'b0, in1} + {1'b0, ~in2} + {{WIDTH{1'b0}}, 1'b1};
    add_ov   = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_sum[WIDTH-1] != in1[WIDTH-1]);
    sub_ov   = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_diff[WIDTH-1] != in1[WIDTH-1]);
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ov     = 1'b0;
    alu_valid  = 1'b1;
    case (op)
      4'd0: alu_result = in1 & in2;
      4'd1: alu_result = in1 | in2;
      4'd2: begin
        alu_result = add_sum[WIDTH-1:0];
        alu_carry  = add_sum[WIDTH];
        alu_ov     = add_ov;
      end
      4'd3: begin
        alu_result = sub_diff[WIDTH-1:0];
        alu_carry  = sub_diff[WIDTH];
        alu_ov     = sub_ov;
      end
      4'd4: alu_result = {{(WIDTH-1){1'b0}}, sub_diff[WIDTH-1] ^ sub_ov};
      4'd5: alu_result = {{(WIDTH-1){1'b0}}, ~sub_diff[WIDTH]};
      4'd6: alu_result = ~(in1 | in2);
      4'd7: alu_result = in1 ^ in2;
      default: alu_valid = 1'b0;
    endcase
  end

  // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? operand : {WIDTH{1'b0}})};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
    div_ok    = ~div_diff[WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand   <= '0;
      is_div    <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (is_multi) begin
              is_div  <= (op == 4'd9);
              operand <= (op == 4'd9) ? in2 : in1;
              acc_lo  <= (op == 4'd9) ? in1 : in2;
              acc_hi  <= '0;
              count   <= CNT_INIT;
            end else begin
              result    <= alu_result;
              result_hi <= '0;
              carry_out <= alu_carry;
              overflow  <= alu_ov;
              zero      <= alu_valid && (alu_result == '0);
            end
          end
        end
        RUN: begin
          if (count != '0) begin
            count <= count - CW'(1);
            if (is_div) begin
              acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
          end else begin
            result    <= acc_lo;
            result_hi <= acc_hi;
            carry_out <= 1'b0;
            overflow  <= is_div ? (operand == '0) : (acc_hi != '0);
            zero      <= (acc_lo == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu at WIDTH=8: expected results are queued
// from a behavioural model when an operation is issued and checked at done.
module tb_multicycle_alu;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst, start;
  logic [3:0] op;
  logic [W-1:0] in1, in2;
  logic ready, done, carry_out, overflow, zero;
  logic [W-1:0] result, result_hi;

  typedef struct packed {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic c;
    logic v;
    logic z;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in1(in1), .in2(in2),
    .ready(ready), .done(done), .result(result), .result_hi(result_hi),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa, sbv, s;
    logic [2*W-1:0] p;
    e = '0;
    sa = $signed(a);
    sbv = $signed(b);
    case (o)
      4'd0: e.r = a & b;
      4'd1: e.r = a | b;
      4'd2: begin
        {e.c, e.r} = {1'b0, a} + {1'b0, b};
        s = sa + sbv;
        e.v = (s > 127) || (s < -128);
      end
      4'd3: begin
        e.r = a - b;
        e.c = (a >= b);
        s = sa - sbv;
        e.v = (s > 127) || (s < -128);
      end
      4'd4: e.r = (sa < sbv) ? 8'd1 : 8'd0;
      4'd5: e.r = (a < b) ? 8'd1 : 8'd0;
      4'd6: e.r = ~(a | b);
      4'd7: e.r = a ^ b;
      4'd8: begin
        p = {8'd0, a} * {8'd0, b};
        e.r = p[W-1:0];
        e.h = p[2*W-1:W];
        e.v = (e.h != 8'd0);
      end
      4'd9: begin
        if (b == 8'd0) begin
          e.r = 8'hFF;
          e.h = a;
          e.v = 1'b1;
        end else begin
          e.r = a / b;
          e.h = a % b;
        end
      end
      default: ;
    endcase
    e.z = (o <= 4'd9) && (e.r == 8'd0);
    return e;
  endfunction

  function automatic int latency(input logic [3:0] o);
    return (o == 4'd8 || o == 4'd9) ? W + 2 : 1;
  endfunction

  task automatic applyStimulus(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op = o;
    in1 = a;
    in2 = b;
    sb.push_back(model(o, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    op = ~o;
    in1 = ~a;
    in2 = b + 8'd3;
  endtask

  task automatic wait_done(input int limit, output int cycles, output bit ready_low_ok);
    cycles = -1;
    ready_low_ok = 1'b1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done) begin
        cycles = i;
        break;
      end
      if (ready) ready_low_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    op = '0;
    in1 = '0;
    in2 = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({result, result_hi, carry_out, overflow, zero, ready, done} !== {19'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state got=%h exp=%h",
               {result, result_hi, carry_out, overflow, zero, ready, done}, {19'd0, 1'b1, 1'b0});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    exp_t e, got;
    int cyc;
    bit rl;
    applyStimulus(4'd2, 8'h7F, 8'h01);
    wait_done(5, cyc, rl);
    vectors++;
    if (cyc !== 1) begin
      miscompares++;
      $display("[TB] FAIL add_latency got=%0d exp=1", cyc);
    end
    e = sb.pop_front();
    got = {result, result_hi, carry_out, overflow, zero};
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("[TB] FAIL add_value got=%h exp=%h", got, e);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL add_done_width got=%b exp=0", done);
    end
  endtask

  task automatic test_single_ops();
    logic [3:0] ops [10] = '{4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd6, 4'd7, 4'd3, 4'd12, 4'd4};
    logic [W-1:0] as [10] = '{8'h05, 8'hFF, 8'hFF, 8'hF0, 8'h0F, 8'hFF, 8'hA5, 8'h03, 8'h55, 8'h80};
    logic [W-1:0] bs [10] = '{8'h05, 8'h01, 8'h01, 8'h3C, 8'h30, 8'h00, 8'hA5, 8'h05, 8'hAA, 8'h7F};
    exp_t e, got;
    int cyc;
    bit rl;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(ops[i], as[i], bs[i]);
      wait_done(5, cyc, rl);
      e = sb.pop_front();
      got = {result, result_hi, carry_out, overflow, zero};
      vectors++;
      if (cyc !== 1 || got !== e) begin
        miscompares++;
        $display("[TB] FAIL single_op%0d op=%0d got=%h/%0d exp=%h/1", i, ops[i], got, cyc, e);
      end
    end
  endtask

  task automatic test_mulu();
    exp_t e, got;
    int cyc;
    bit rl;
    applyStimulus(4'd8, 8'hFF, 8'hFF);
    wait_done(20, cyc, rl);
    vectors++;
    if (cyc !== W + 2 || rl !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mulu_timing got=%0d/%b exp=%0d/1", cyc, rl, W + 2);
    end
    e = sb.pop_front();
    got = {result, result_hi, carry_out, overflow, zero};
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("[TB] FAIL mulu_value got=%h exp=%h", got, e);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mulu_after_done got=%b%b exp=01", done, ready);
    end
  endtask

  task automatic test_divu();
    logic [W-1:0] as [4] = '{8'd100, 8'd42, 8'd255, 8'd7};
    logic [W-1:0] bs [4] = '{8'd7, 8'd0, 8'd1, 8'd200};
    exp_t e, got;
    int cyc;
    bit rl;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'd9, as[i], bs[i]);
      wait_done(20, cyc, rl);
      e = sb.pop_front();
      got = {result, result_hi, carry_out, overflow, zero};
      vectors++;
      if (cyc !== W + 2 || rl !== 1'b1 || got !== e) begin
        miscompares++;
        $display("[TB] FAIL divu%0d got=%h/%0d/%b exp=%h/%0d/1", i, got, cyc, rl, e, W + 2);
      end
    end
  endtask

  task automatic test_ignore_start();
    exp_t e, got;
    int cyc, extra;
    bit rl;
    applyStimulus(4'd8, 8'h0D, 8'h0B);
    repeat (3) begin
      @(negedge clk);
      start = 1'b1;
      op = 4'd2;
      in1 = 8'($urandom);
      in2 = 8'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(20, cyc, rl);
    e = sb.pop_front();
    got = {result, result_hi, carry_out, overflow, zero};
    vectors++;
    if (cyc < 0 || rl !== 1'b1 || got !== e) begin
      miscompares++;
      $display("[TB] FAIL ignore_start got=%h/%0d/%b exp=%h", got, cyc, rl, e);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("[TB] FAIL ignore_extra_done got=%0d exp=0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [4] = '{4'd2, 4'd3, 4'd7, 4'd5};
    logic [W-1:0] as [4] = '{8'd10, 8'd1, 8'hAA, 8'd3};
    logic [W-1:0] bs [4] = '{8'd20, 8'd2, 8'h55, 8'd9};
    exp_t e, got;
    int cyc;
    bit rl;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      start = 1'b1;
      op = ops[i];
      in1 = as[i];
      in2 = bs[i];
      sb.push_back(model(ops[i], as[i], bs[i]));
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      got = {result, result_hi, carry_out, overflow, zero};
      vectors++;
      if (done !== 1'b1 || got !== e) begin
        miscompares++;
        $display("[TB] FAIL b2b%0d done=%b got=%h exp=%h", i, done, got, e);
      end
    end
    op = 4'd8;
    in1 = 8'd13;
    in2 = 8'd21;
    sb.push_back(model(4'd8, 8'd13, 8'd21));
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(20, cyc, rl);
    e = sb.pop_front();
    got = {result, result_hi, carry_out, overflow, zero};
    vectors++;
    if (cyc !== W + 2 || got !== e) begin
      miscompares++;
      $display("[TB] FAIL b2b_mulu got=%h/%0d exp=%h/%0d", got, cyc, e, W + 2);
    end
  endtask

  task automatic test_random();
    exp_t e, got;
    int cyc;
    bit rl;
    logic [3:0] o;
    logic [W-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 4'($urandom_range(0, 15));
      a = 8'($urandom);
      b = 8'($urandom);
      applyStimulus(o, a, b);
      wait_done(20, cyc, rl);
      e = sb.pop_front();
      got = {result, result_hi, carry_out, overflow, zero};
      vectors++;
      if (cyc !== latency(o) || got !== e) begin
        miscompares++;
        $display("[TB] FAIL rand%0d op=%0d a=%h b=%h got=%h/%0d exp=%h/%0d",
                 i, o, a, b, got, cyc, e, latency(o));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e, got;
    int cyc, seen;
    bit rl;
    applyStimulus(4'd9, 8'd100, 8'd7);
    repeat (4) @(posedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({result, result_hi, carry_out, overflow, zero, ready, done} !== {19'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL midrun_reset got=%h exp=%h",
               {result, result_hi, carry_out, overflow, zero, ready, done}, {19'd0, 1'b1, 1'b0});
    end
    e = sb.pop_front();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("[TB] FAIL midrun_no_done got=%0d exp=0", seen);
    end
    applyStimulus(4'd2, 8'd3, 8'd4);
    wait_done(5, cyc, rl);
    e = sb.pop_front();
    got = {result, result_hi, carry_out, overflow, zero};
    vectors++;
    if (cyc !== 1 || got !== e || result !== 8'd7) begin
      miscompares++;
      $display("[TB] FAIL post_reset_add got=%h/%0d exp=%h/1", got, cyc, e);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_single_ops();
    test_mulu();
    test_divu();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
